dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data memory port (separate read/write address, 32-bit data) between two requesters: port 0 (CPU load/store unit) and port 1 (auxiliary master, e.g. array loader/checker).
- One memory access per granted cycle. Round-robin arbitration with a burst quantum, so a streaming requester cannot starve the other.
- Sits between the requesters and the data_memory instance. Drives its r_addr/w_addr/r_en/w_en/w_data and consumes its r_data.

Parameters:
- B, 8, byte width; data words are 4*B bits.
- N, 8, address width.
- MAX_BURST, 4, maximum consecutive grants to one port while the other port is requesting (must be >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0, req1  in  1  access request from port 0 / port 1.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  N  word address.
- wdata0, wdata1  in  4*B  write data.
- gnt0, gnt1  out  1  combinational grant; the access is performed in this cycle.
- rvalid0, rvalid1  out  1  registered one-cycle pulse: read data valid.
- rdata0, rdata1  out  4*B  registered read data, held until the next read completes on that port.
- mem_r_addr, mem_w_addr  out  N  to memory.
- mem_r_en, mem_w_en  out  1  to memory.
- mem_w_data  out  4*B  to memory.
- mem_r_data  in  4*B  from memory, valid one cycle after mem_r_en.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, priority pointer = port 0, burst counter = 0.
  - rvalid0/1 = 0, rdata0/1 = 0.
  - gnt0/1, mem_r_en, mem_w_en = 0 while rst is high.
- FSM states:
  - IDLE: grants allowed.
  - RD_WAIT: read issued last cycle; no grants.
  - RD_DONE does not exist. Capture happens at the RD_WAIT→IDLE edge.
- IDLE arbitration, per cycle:
  - Only one requester active: it is granted.
  - Both active: the port named by the priority pointer is granted.
  - Neither active: no grant; all memory enables are 0.
- Granted write:
  - mem_w_en=1, mem_w_addr=addrX, mem_w_data=wdataX in the same cycle.
  - State stays IDLE, so back-to-back writes proceed every cycle.
- Granted read:
  - mem_r_en=1, mem_r_addr=addrX in the same cycle; next state RD_WAIT.
  - The port ID is recorded in a register.
- RD_WAIT (exactly 1 cycle):
  - gnt0/1 = 0.
  - At the clock edge ending RD_WAIT, mem_r_data is registered into rdataX and rvalidX=1 for one cycle.
  - Return to IDLE. A new grant may coincide with that rvalid cycle.
- Read latency: gnt in cycle T, rvalidX/rdataX in cycle T+2. Read throughput is 1 per 2 cycles.
- Write latency: the write takes effect at the end of the grant cycle. A read of the same address granted at T+1 or later returns the new data.
- Requester rule: req/we/addr/wdata are held stable until gnt is seen. Deasserting req before gnt withdraws the request with no side effects.
- Burst counter and priority pointer, updated on each grant only:
  - Counter increments while the same port is granted consecutively.
  - When the count reaches MAX_BURST and the other port is requesting, the pointer moves to the other port and the counter clears.
  - Granting a different port sets the counter to 1 and points the pointer away from the granted port.
  - Pointer and counter are unchanged when there is no grant.
- Unused memory address/data outputs are driven to 0 when the corresponding enable is 0.
- Reset during RD_WAIT: the pending read is discarded, no rvalid pulse is produced, and the state is IDLE after reset.
- Never assert gnt0 and gnt1 together; never assert mem_r_en and mem_w_en together.

Test Plan:
- Reset then single write/read: port0 writes 0xDEADBEEF to addr 0x10. Port0 reads addr 0x10 → gnt0 at T, rvalid0 at T+2 with rdata0=0xDEADBEEF. rvalid1 stays 0.
- Contention: both ports request reads (addr0=0x01, addr1=0x02) from reset. Port0 is granted first, port1 next, in cycles T and T+2. The rvalid pulses carry the respective memory contents.
- Burst quantum with MAX_BURST=4: port0 issues continuous writes while port1 holds a write request. Expect gnt0 for 4 consecutive cycles, then gnt1, then gnt0 resumes. Port1 waits no more than 4 cycles.
- Idle fairness: only port1 requests 10 writes → gnt1 every cycle with no gaps. Pointer and counter evolve per the burst rule.
- Reset mid-read: assert rst during RD_WAIT → no rvalid pulse, outputs at reset values. A post-reset read of the same address completes normally.
- Write-then-read hazard: port1 writes 0x12345678 to 0x20 at T, port0 reads 0x20 at T+1 → rdata0=0x12345678 at T+3.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between two requesters.
// Round-robin arbitration with a burst quantum; reads take two cycles
// (issue, then RD_WAIT), writes complete in the grant cycle.
module dmem_arbiter #(
    parameter int B         = 8,
    parameter int N         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic           req1,
    input  logic           we0,
    input  logic           we1,
    input  logic [N-1:0]   addr0,
    input  logic [N-1:0]   addr1,
    input  logic [4*B-1:0] wdata0,
    input  logic [4*B-1:0] wdata1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           rvalid0,
    output logic           rvalid1,
    output logic [4*B-1:0] rdata0,
    output logic [4*B-1:0] rdata1,
    output logic [N-1:0]   mem_r_addr,
    output logic [N-1:0]   mem_w_addr,
    output logic           mem_r_en,
    output logic           mem_w_en,
    output logic [4*B-1:0] mem_w_data,
    input  logic [4*B-1:0] mem_r_data
);

    localparam int W  = 4 * B;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_ptr;       // port that wins when both request
    logic            r_last;      // port granted most recently
    logic [CW-1:0]   r_cnt;       // consecutive grants to r_last
    logic            r_rd_port;   // port owning the outstanding read
    logic            r_rvalid0;
    logic            r_rvalid1;
    logic [W-1:0]    r_rdata0;
    logic [W-1:0]    r_rdata1;

    state_t          w_state_next;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_grant;
    logic            w_port;
    logic            w_we;
    logic            w_other_req;
    logic [N-1:0]    w_addr;
    logic [W-1:0]    w_wdata;
    logic            w_ptr_next;
    logic            w_last_next;
    logic [CW-1:0]   w_cnt_next;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_rd_port_next;

    // Arbitration, next state and memory-side drive for this cycle
    always_comb begin
        w_state_next = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        if (rst) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req0 && req1) begin
                        if (r_ptr) begin
                            w_gnt1 = 1'b1;
                        end else begin
                            w_gnt0 = 1'b1;
                        end
                    end else if (req0) begin
                        w_gnt0 = 1'b1;
                    end else if (req1) begin
                        w_gnt1 = 1'b1;
                    end else begin
                        w_gnt0 = 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end

        w_grant     = w_gnt0 | w_gnt1;
        w_port      = w_gnt1;
        w_we        = w_gnt1 ? we1 : we0;
        w_addr      = w_gnt1 ? addr1 : addr0;
        w_wdata     = w_gnt1 ? wdata1 : wdata0;
        w_other_req = w_gnt1 ? req0 : req1;

        mem_r_en   = w_grant & ~w_we;
        mem_w_en   = w_grant & w_we;
        mem_r_addr = mem_r_en ? w_addr : {N{1'b0}};
        mem_w_addr = mem_w_en ? w_addr : {N{1'b0}};
        mem_w_data = mem_w_en ? w_wdata : {W{1'b0}};

        if (mem_r_en) begin
            w_state_next   = ST_RD_WAIT;
            w_rd_port_next = w_port;
        end else begin
            w_rd_port_next = r_rd_port;
        end
    end

    // Burst counter and priority pointer; they move only on a grant
    always_comb begin
        w_ptr_next  = r_ptr;
        w_last_next = r_last;
        w_cnt_next  = r_cnt;
        w_cnt_inc   = (r_cnt >= CNT_MAX) ? CNT_MAX : (r_cnt + CNT_ONE);
        if (w_grant) begin
            w_last_next = w_port;
            if (w_port == r_last) begin
                if ((w_cnt_inc == CNT_MAX) && w_other_req) begin
                    w_ptr_next = ~w_port;
                    w_cnt_next = CNT_ZERO;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end else begin
                w_ptr_next = ~w_port;
                w_cnt_next = CNT_ONE;
            end
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // State, arbitration bookkeeping and read-return registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 1'b0;
            r_last    <= 1'b0;
            r_cnt     <= CNT_ZERO;
            r_rd_port <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= {W{1'b0}};
            r_rdata1  <= {W{1'b0}};
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_last    <= w_last_next;
            r_cnt     <= w_cnt_next;
            r_rd_port <= w_rd_port_next;
            r_rvalid0 <= (r_state == ST_RD_WAIT) && (r_rd_port == 1'b0);
            r_rvalid1 <= (r_state == ST_RD_WAIT) && (r_rd_port == 1'b1);
            if ((r_state == ST_RD_WAIT) && (r_rd_port == 1'b0)) begin
                r_rdata0 <= mem_r_data;
            end
            if ((r_state == ST_RD_WAIT) && (r_rd_port == 1'b1)) begin
                r_rdata1 <= mem_r_data;
            end
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule
